// File: rtl/clock_edge_tracker.sv
// Samples a slow derived clock in the clk_i domain, emits rise/fall strobes, measures the rise-to-rise period and tracks lock.
// Optional macro CLK_EDGE_TRACKER_TIMEOUT_EN enables the stall timeout when no rise arrives before the counter saturates.
module clock_edge_tracker #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 8,
   parameter int LOCK_COUNT  = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clk_slow_i,
   output logic             rise_o,
   output logic             fall_o,
   output logic [CNT_W-1:0] period_o,
   output logic             period_valid_o,
   output logic             lock_o,
   output logic             err_o,
   output logic             stall_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] LOCK_N  = CNT_W'(LOCK_COUNT);

   typedef enum logic [1:0] {IDLE, MEASURE, TRACK, LOCKED} state_t;

   state_t           state, state_n;
   logic [SYNC_STAGES-1:0] sync_q;
   logic             s, s_d;
   logic             rise_det, fall_det, timeout;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] ref_q, ref_n;
   logic [CNT_W-1:0] match_q, match_n;
   logic [CNT_W-1:0] period_n;
   logic             pv_n, lock_n, err_n, stall_n;

   assign s        = sync_q[SYNC_STAGES-1];
   assign rise_det = s & ~s_d;
   assign fall_det = ~s & s_d;

`ifdef CLK_EDGE_TRACKER_TIMEOUT_EN
   assign timeout = ~rise_det & (cnt == CNT_MAX);
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= '0;
         s_d    <= 1'b0;
         rise_o <= 1'b0;
         fall_o <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], clk_slow_i};
         s_d    <= s;
         rise_o <= rise_det;
         fall_o <= fall_det;
      end
   end

   // Counter value seen at a rise is the number of cycles since the previous rise.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt <= '0;
      end else if (rise_det) begin
         cnt <= CNT_ONE;
      end else if (cnt != CNT_MAX) begin
         cnt <= cnt + CNT_ONE;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state          <= IDLE;
         ref_q          <= '0;
         match_q        <= '0;
         period_o       <= '0;
         period_valid_o <= 1'b0;
         lock_o         <= 1'b0;
         err_o          <= 1'b0;
         stall_o        <= 1'b0;
      end else begin
         state          <= state_n;
         ref_q          <= ref_n;
         match_q        <= match_n;
         period_o       <= period_n;
         period_valid_o <= pv_n;
         lock_o         <= lock_n;
         err_o          <= err_n;
         stall_o        <= stall_n;
      end
   end

   always_comb begin
      state_n  = state;
      ref_n    = ref_q;
      match_n  = match_q;
      period_n = period_o;
      pv_n     = 1'b0;
      lock_n   = lock_o;
      err_n    = 1'b0;
      stall_n  = stall_o;
      if (rise_det) begin
         stall_n = 1'b0;
         case (state)
            IDLE: state_n = MEASURE;
            MEASURE: begin
               period_n = cnt;
               pv_n     = 1'b1;
               ref_n    = cnt;
               match_n  = CNT_ONE;
               if (LOCK_COUNT == 1) begin
                  state_n = LOCKED;
                  lock_n  = 1'b1;
               end else begin
                  state_n = TRACK;
               end
            end
            TRACK: begin
               period_n = cnt;
               pv_n     = 1'b1;
               if (cnt == ref_q) begin
                  match_n = match_q + CNT_ONE;
                  if (match_n == LOCK_N) begin
                     state_n = LOCKED;
                     lock_n  = 1'b1;
                  end
               end else begin
                  ref_n   = cnt;
                  match_n = CNT_ONE;
               end
            end
            LOCKED: begin
               period_n = cnt;
               pv_n     = 1'b1;
               // A deviation while locked is the only case that raises err_o.
               if (cnt != ref_q) begin
                  err_n   = 1'b1;
                  lock_n  = 1'b0;
                  ref_n   = cnt;
                  match_n = CNT_ONE;
                  state_n = TRACK;
               end
            end
            default: state_n = IDLE;
         endcase
      end else if (timeout) begin
         stall_n = 1'b1;
         lock_n  = 1'b0;
         state_n = IDLE;
      end
   end

endmodule
